// File: rtl/alu_result_buffer.sv
// Result FIFO between the ALU and writeback: sanitises results, attaches {ill,dz,neg,zero} flags at push.
// Optional ALU_RESULT_BUFFER_STATS_EN adds stat_pops / stat_exc counters.
module alu_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_result,
  input  logic [3:0]                 in_opcode,
  input  logic [31:0]                in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_result,
  output logic [3:0]                 out_opcode,
  output logic [3:0]                 out_flags,
`ifdef ALU_RESULT_BUFFER_STATS_EN
  output logic [31:0]                stat_pops,
  output logic [15:0]                stat_exc,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] result;
    logic [3:0]  opcode;
    logic [3:0]  flags;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  entry_t          new_entry;
  logic            ill, dz, neg;
  logic [63:0]     san_result;

  // Handshake flags come only from registered count: no out_ready -> in_ready path.
  assign in_ready  = (count_q != FULL_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    ill        = in_opcode[3];
    dz         = !in_opcode[3] && (in_opcode[1:0] == 2'b11) && (in_b == 32'd0);
    san_result = (ill || dz) ? 64'd0 : in_result;
    neg        = (in_opcode[3:2] == 2'b01) && !dz && san_result[63];
    new_entry  = '{result: san_result, opcode: in_opcode,
                   flags: {ill, dz, neg, (san_result == 64'd0)}};
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; contents are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= new_entry;
  end

  assign out_result = mem_q[rptr_q].result;
  assign out_opcode = mem_q[rptr_q].opcode;
  assign out_flags  = mem_q[rptr_q].flags;
  assign count      = count_q;

`ifdef ALU_RESULT_BUFFER_STATS_EN
  logic [31:0] pops_q, pops_d;
  logic [15:0] exc_q, exc_d;

  always_comb begin
    pops_d = pops_q;
    exc_d  = exc_q;
    if (pop) pops_d = pops_q + 32'd1;
    if (push && (ill || dz) && (exc_q != 16'hFFFF)) exc_d = exc_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pops_q <= '0;
      exc_q  <= '0;
    end else begin
      pops_q <= pops_d;
      exc_q  <= exc_d;
    end
  end

  assign stat_pops = pops_q;
  assign stat_exc  = exc_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer (DEPTH=4): flags, full/empty, wrap, mid-operation reset.
module tb_alu_result_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_result, out_result;
  logic [3:0]  in_opcode, out_opcode, out_flags;
  logic [31:0] in_b;
  logic [2:0]  count;
`ifdef ALU_RESULT_BUFFER_STATS_EN
  logic [31:0] stat_pops;
  logic [15:0] stat_exc;
`endif

  int tests = 0;
  int fails = 0;

  alu_result_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_opcode(in_opcode), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode), .out_flags(out_flags),
`ifdef ALU_RESULT_BUFFER_STATS_EN
    .stat_pops(stat_pops), .stat_exc(stat_exc),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] r, input logic [3:0] op, input logic [31:0] b);
    in_valid = 1'b1; in_result = r; in_opcode = op; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_result = '0; in_opcode = '0; in_b = '0;
    #12;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    push(64'h5, 4'b0000, 32'd1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", out_valid); end
    tests++; if (out_result !== 64'h5) begin fails++; $display("FAIL basic_result got %h want 5", out_result); end
    tests++; if (out_flags !== 4'b0000) begin fails++; $display("FAIL basic_flags got %b want 0000", out_flags); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL basic_count got %0d want 1", count); end
    pop1();
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_pop count %0d valid %b want 0 0", count, out_valid); end
  endtask

  task automatic test_div_zero();
    push(64'hDEAD, 4'b0011, 32'd0);
    push(64'hBEEF, 4'b0111, 32'd3);
    tests++; if (out_result !== 64'h0) begin fails++; $display("FAIL dz_result got %h want 0", out_result); end
    tests++; if (out_flags !== 4'b0101) begin fails++; $display("FAIL dz_flags got %b want 0101", out_flags); end
    tests++; if (out_opcode !== 4'b0011) begin fails++; $display("FAIL dz_opcode got %b want 0011", out_opcode); end
    pop1();
    tests++; if (out_result !== 64'hBEEF) begin fails++; $display("FAIL nodz_result got %h want beef", out_result); end
    tests++; if (out_flags !== 4'b0000) begin fails++; $display("FAIL nodz_flags got %b want 0000", out_flags); end
    pop1();
  endtask

  task automatic test_neg_ill();
    push(64'hFFFF_FFFF_FFFF_FFFF, 4'b0101, 32'd1);
    push(64'hFFFF_FFFF_FFFF_FFFF, 4'b0001, 32'd1);
    push(64'h7, 4'b1000, 32'd0);
    tests++; if (out_flags !== 4'b0010) begin fails++; $display("FAIL neg_signed_flags got %b want 0010", out_flags); end
    tests++; if (out_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL neg_result got %h want all ones", out_result); end
    pop1();
    tests++; if (out_flags !== 4'b0000) begin fails++; $display("FAIL neg_unsigned_flags got %b want 0000", out_flags); end
    pop1();
    tests++; if (out_result !== 64'h0) begin fails++; $display("FAIL ill_result got %h want 0", out_result); end
    tests++; if (out_flags !== 4'b1001) begin fails++; $display("FAIL ill_flags got %b want 1001", out_flags); end
    pop1();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL neg_ill_drain count %0d want 0", count); end
  endtask

  task automatic test_full();
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_before%0d got %b want 1", i, in_ready); end
      push(64'd10 + 64'(i), 4'b0000, 32'd1);
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", in_ready); end
    push(64'd14, 4'b0000, 32'd1);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count got %0d want 4", count); end
    // pop with push offered at full: push is blocked, only the pop happens
    in_valid = 1'b1; in_result = 64'd99; out_ready = 1'b1;
    tests++; if (out_result !== 64'd10) begin fails++; $display("FAIL drain0 got %0d want 10", out_result); end
    tick();
    in_valid = 1'b0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_pushpop count %0d want 3", count); end
    for (int i = 1; i < 4; i++) begin
      exp = 64'd10 + 64'(i);
      tests++; if (out_result !== exp) begin fails++; $display("FAIL drain%0d got %0d want %0d", i, out_result, exp); end
      tick();
    end
    out_ready = 1'b0;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty count %0d valid %b want 0 0", count, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    push(64'd100, 4'b0000, 32'd1);
    push(64'd101, 4'b0000, 32'd1);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = 64'd102 + 64'(i);
      exp = 64'd100 + 64'(i);
      tests++; if (out_result !== exp) begin fails++; $display("FAIL b2b_head%0d got %0d want %0d", i, out_result, exp); end
      tick();
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count%0d got %0d want 2", i, count); end
    end
    in_valid = 1'b0;
    tests++; if (out_result !== 64'd110) begin fails++; $display("FAIL b2b_tail0 got %0d want 110", out_result); end
    tick();
    tests++; if (out_result !== 64'd111) begin fails++; $display("FAIL b2b_tail1 got %0d want 111", out_result); end
    tick();
    out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_empty got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    push(64'h1, 4'b1000, 32'd0);
    push(64'h2, 4'b0000, 32'd1);
    push(64'h3, 4'b0000, 32'd1);
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL rmid_pre count %0d want 3", count); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL rmid_async count %0d valid %b want 0 0", count, out_valid); end
`ifdef ALU_RESULT_BUFFER_STATS_EN
    tests++; if (stat_pops !== 32'd0 || stat_exc !== 16'd0) begin fails++; $display("FAIL rmid_stats pops %0d exc %0d want 0 0", stat_pops, stat_exc); end
`endif
    in_valid = 1'b1; out_ready = 1'b1; in_result = 64'h55;
    tick();
    tests++; if (count !== 3'd0 || in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ignore count %0d ready %b want 0 1", count, in_ready); end
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    push(64'h77, 4'b0000, 32'd1);
    tests++; if (out_result !== 64'h77 || count !== 3'd1) begin fails++; $display("FAIL rmid_first result %h count %0d want 77 1", out_result, count); end
    pop1();
  endtask

`ifdef ALU_RESULT_BUFFER_STATS_EN
  task automatic test_stats();
    // After mid reset: one pop of 0x77; push two exceptions and pop one.
    push(64'h9, 4'b1010, 32'd1);
    push(64'h9, 4'b0011, 32'd0);
    push(64'h9, 4'b0010, 32'd0);
    pop1();
    tests++; if (stat_pops !== 32'd2) begin fails++; $display("FAIL stat_pops got %0d want 2", stat_pops); end
    tests++; if (stat_exc !== 16'd2) begin fails++; $display("FAIL stat_exc got %0d want 2", stat_exc); end
  endtask
`endif

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_neg_ill();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef ALU_RESULT_BUFFER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
